// File: rtl/univ_shift_reg.sv
// Universal shift register: eight per-edge modes (hold/shift/load/rotate/ASR/clear),
// single-cycle ops from IDLE, and a counted burst engine with busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [2:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] remain_reg, remain_next;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_result;

  // In a burst the latched mode drives the datapath; otherwise the live mode.
  assign op_mode = (state_reg == BURST) ? mode_reg : mode;

  always_comb begin
    op_result = q_reg;
    case (op_mode)
      M_HOLD:  op_result = q_reg;
      M_SHR:   op_result = {sin_r, q_reg[WIDTH-1:1]};
      M_SHL:   op_result = {q_reg[WIDTH-2:0], sin_l};
      M_LOAD:  op_result = d;
      M_ROR:   op_result = {q_reg[0], q_reg[WIDTH-1:1]};
      M_ROL:   op_result = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      M_ASR:   op_result = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
      M_CLEAR: op_result = '0;
      default: op_result = q_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    mode_next   = mode_reg;
    remain_next = remain_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next   = mode;
          remain_next = count;
          state_next  = (count == '0) ? DONE : BURST;
        end else if (en) begin
          q_next = op_result;
        end
      end
      BURST: begin
        q_next      = op_result;
        remain_next = remain_reg - 1'b1;
        if (remain_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      mode_reg   <= '0;
      remain_reg <= '0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      mode_reg   <= mode_next;
      remain_reg <= remain_next;
    end
  end

  assign q      = q_reg;
  assign sout_r = q_reg[0];
  assign sout_l = q_reg[WIDTH-1];
  assign busy   = (state_reg == BURST);
  assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4, CNT_W=3) with hand-computed expectations.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       start;
  logic [2:0] count;
  logic [3:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .count  (count),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s q=%b busy=%b done=%b observed=%0h expected=%0h", tag, q, busy, done, obs, exp);
  endtask

  task automatic chk_status(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 3'b000; d = 4'h0;
    sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; count = 3'd0;

    // asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1 chk_status("rst_async", 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_status("rst_release", 4'h0, 1'b0, 1'b0);

    // parallel load and hold
    en = 1'b1; mode = 3'b011; d = 4'b1001; tick();
    chk("load_1001", {28'd0, q}, 32'h9);
    d = 4'b1011; tick();
    chk("load_1011", {28'd0, q}, 32'hB);
    en = 1'b0; d = 4'b1111; tick();
    chk("en0_hold", {28'd0, q}, 32'hB);

    // serial shifts
    en = 1'b1; mode = 3'b011; d = 4'b1001; tick();
    mode = 3'b001; sin_r = 1'b1; tick();
    chk("shr", {28'd0, q}, 32'hC);
    chk("shr_sout_r", {31'd0, sout_r}, 32'd0);
    mode = 3'b010; sin_l = 1'b1; tick();
    chk("shl", {28'd0, q}, 32'h9);
    chk("shl_sout_l", {31'd0, sout_l}, 32'd1);
    chk("shl_sout_r", {31'd0, sout_r}, 32'd1);
    mode = 3'b011; d = 4'b1000; tick();
    mode = 3'b110; tick();
    chk("asr", {28'd0, q}, 32'hC);
    mode = 3'b111; tick();
    chk("clear", {28'd0, q}, 32'h0);

    // single rotates
    mode = 3'b011; d = 4'b1011; tick();
    mode = 3'b100; tick();
    chk("ror", {28'd0, q}, 32'hD);
    mode = 3'b101; tick();
    chk("rol", {28'd0, q}, 32'hB);
    en = 1'b0; mode = 3'b000;

    // burst rotate-left x3 from 1011, with mode/en disturbed mid-burst
    start = 1'b1; mode = 3'b101; count = 3'd3; tick();
    chk_status("burst_e0", 4'hB, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b111; en = 1'b1; count = 3'd0; tick();
    chk_status("burst_e1", 4'h7, 1'b1, 1'b0);
    mode = 3'b011; d = 4'h0; tick();
    chk_status("burst_e2", 4'hE, 1'b1, 1'b0);
    en = 1'b0; mode = 3'b000; tick();
    chk_status("burst_e3", 4'hD, 1'b0, 1'b1);
    // start is ignored while in DONE
    start = 1'b1; mode = 3'b111; count = 3'd0; tick();
    chk_status("done_ign_start", 4'hD, 1'b0, 1'b0);
    start = 1'b0;

    // count=0 with start beating en
    start = 1'b1; en = 1'b1; mode = 3'b011; d = 4'h0; count = 3'd0; tick();
    chk_status("cnt0_e0", 4'hD, 1'b0, 1'b1);
    start = 1'b0; en = 1'b0; mode = 3'b000; tick();
    chk_status("cnt0_after", 4'hD, 1'b0, 1'b0);

    // burst shift right x7 from 1101, reset asserted after E2
    start = 1'b1; mode = 3'b001; count = 3'd7; sin_r = 1'b0; tick();
    chk_status("sr7_e0", 4'hD, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; tick();
    chk_status("sr7_e1", 4'h6, 1'b1, 1'b0);
    sin_r = 1'b1; tick();
    chk_status("sr7_e2", 4'hB, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_status("mid_rst", 4'h0, 1'b0, 1'b0);
    tick();
    chk_status("rst_hold", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1; tick();
    chk_status("post_rst", 4'h0, 1'b0, 1'b0);
    en = 1'b1; mode = 3'b011; d = 4'b0101; tick();
    chk_status("op_after_rst", 4'h5, 1'b0, 1'b0);
    en = 1'b0; tick();
    chk_status("idle_final", 4'h5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
